demux8_reg: RTL and testbench

- Registered 1-to-8 demultiplexer with handshake: the write-side counterpart of the datapath/monitor 8-way select.
- A producer presents a select and a data word; the block steers the word into one of 8 holding registers.
- Each holding register carries a valid flag until its consumer acknowledges it.
- Used to fan the monitor's single write path out to 8 independent debug/peripheral sinks.

---
 rtl/demux8_pkg.sv | 23 ++
 rtl/demux8_slot.sv | 44 ++++
 rtl/demux8_reg.sv | 90 +++++++++
 tb/tb_demux8_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// demux8_pkg: shared constants, types and helpers for the demux8_reg block.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package demux8_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OCC_W-1:0] occ_t;

  // Number of set bits in a per-channel mask.
  function automatic occ_t popcnt(input logic [NCH-1:0] v);
    occ_t c;
    c = '0;
    for (int i = 0; i < NCH; i++) begin
      c = c + occ_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/demux8_slot.sv
// demux8_slot: one channel holding register with valid flag and sticky overwrite flag.
// Latency: write visible on q/valid one cycle after wr_en.
// Backpressure: none locally; a same-cycle write beats ack. Overwrite tracking only with DEMUX8_OVERWRITE_EN.
module demux8_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             ovf
);

  // Data and valid: a write sets valid and wins over a same-cycle ack; an ack alone
  // drops valid but keeps the data so a late reader still sees the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX8_OVERWRITE_EN
  // Sticky overwrite flag: a write landed on unconsumed data; cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (wr_en && valid && !ack) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 write demux with per-channel valid/ack (option macro DEMUX8_OVERWRITE_EN).
// Latency: 1 cycle from accepted write to y_s / y_valid[s]; occ tracks popcount(y_valid).
// Backpressure: in_ready = ~y_valid[s] | y_ack[s]; with DEMUX8_OVERWRITE_EN it is tied 1 and overwrites set ovf[s].
module demux8_reg
  import demux8_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  sel_t             s,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [NCH-1:0]   y_valid,
  input  logic [NCH-1:0]   y_ack,
  output occ_t             occ,
  output logic [NCH-1:0]   ovf
);

  logic             xfer;
  logic [NCH-1:0]   wr_mask;
  logic [NCH-1:0]   ack_eff;
  logic             occ_inc;
  occ_t             occ_nxt;
  logic [WIDTH-1:0] q [NCH];

`ifdef DEMUX8_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  // A full channel frees up in the same cycle its sink acks, so ack feeds ready directly.
  assign in_ready = ~y_valid[s] | y_ack[s];
`endif

  assign xfer = in_valid & in_ready;

  // Decode the write and net out the occupancy change; an ack on the channel being
  // written is swallowed by the write, so it must not decrement the count.
  always_comb begin
    wr_mask = '0;
    if (xfer) begin
      wr_mask[s] = 1'b1;
    end
    ack_eff = y_ack & y_valid & ~wr_mask;
    occ_inc = xfer & ~y_valid[s];
    occ_nxt = occ + occ_t'(occ_inc) - popcnt(ack_eff);
  end

  // Occupancy register, kept equal to popcount(y_valid).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
    end else begin
      occ <= occ_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux8_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_mask[i]),
      .ack     (y_ack[i]),
      .d       (d),
      .q       (q[i]),
      .valid   (y_valid[i]),
      .ovf     (ovf[i])
    );
  end

  assign y0 = q[0];
  assign y1 = q[1];
  assign y2 = q[2];
  assign y3 = q[3];
  assign y4 = q[4];
  assign y5 = q[5];
  assign y6 = q[6];
  assign y7 = q[7];

endmodule

// File: tb/tb_demux8_reg.sv
// tb_demux8_reg: directed bench for demux8_reg with a write scoreboard and a small channel model.
// Latency: expects accepted writes on y/y_valid one cycle later.
// Backpressure: expected in_ready derived from the model (tied 1 with DEMUX8_OVERWRITE_EN).
module tb_demux8_reg;

`ifdef DEMUX8_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  s;
  logic [31:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]  y_valid;
  logic [7:0]  y_ack;
  logic [3:0]  occ;
  logic [7:0]  ovf;

  typedef struct {
    int          ch;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mv;
  logic [7:0]  movf;
  logic [31:0] md [8];
  int          n_chk;
  int          n_fail;

  demux8_reg #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .d        (d),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y4       (y4),
    .y5       (y5),
    .y6       (y6),
    .y7       (y7),
    .y_valid  (y_valid),
    .y_ack    (y_ack),
    .occ      (occ),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] y_of(input int ch);
    case (ch)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mv   = '0;
    movf = '0;
    for (int i = 0; i < 8; i++) md[i] = '0;
    sb.delete();
  endtask

  // One clock of stimulus: drive, check ready against the model, push the expected
  // write, clock, then pop and compare everything the DUT should now show.
  task automatic cycle(input logic [2:0] sel, input logic [31:0] dat,
                       input logic vld, input logic [7:0] ack);
    logic       exp_rdy;
    logic [7:0] nv;
    exp_t       e;
    s = sel; d = dat; in_valid = vld; y_ack = ack;
    #1;
    exp_rdy = OVR ? 1'b1 : (~mv[sel] | ack[sel]);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    nv = mv & ~ack;
    if (vld && exp_rdy) begin
      if (OVR && mv[sel] && !ack[sel]) movf[sel] = 1'b1;
      nv[sel] = 1'b1;
      md[sel] = dat;
      sb.push_back('{int'(sel), dat});
    end
    @(posedge clk);
    #1;
    mv = nv;
    in_valid = 1'b0;
    y_ack = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("y%0d_write", e.ch), {32'd0, y_of(e.ch)}, {32'd0, e.dat});
    end
    for (int i = 0; i < 8; i++) chk($sformatf("y%0d_hold", i), {32'd0, y_of(i)}, {32'd0, md[i]});
    chk("y_valid", {56'd0, y_valid}, {56'd0, mv});
    chk("occ", {60'd0, occ}, {60'd0, pop8(mv)});
    chk("occ_popcount", {60'd0, occ}, {60'd0, pop8(y_valid)});
    chk("ovf", {56'd0, ovf}, {56'd0, movf});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    model_clear();

    // Reset held while a write is offered: nothing may be latched.
    reset_n = 1'b0; in_valid = 1'b1; s = 3'd3; d = 32'hDEADBEEF; y_ack = '0;
    #22;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_y%0d", i), {32'd0, y_of(i)}, 64'd0);
    chk("rst_y_valid", {56'd0, y_valid}, 64'h00);
    chk("rst_occ", {60'd0, occ}, 64'd0);
    chk("rst_ovf", {56'd0, ovf}, 64'h00);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("rst_hold_y_valid", {56'd0, y_valid}, 64'h00);
    reset_n = 1'b1;

    cycle(3'd3, 32'hDEADBEEF, 1'b1, 8'h00);
    chk("first_y3", {32'd0, y3}, 64'hDEADBEEF);
    chk("first_y_valid", {56'd0, y_valid}, 64'h08);
    chk("first_occ", {60'd0, occ}, 64'd1);
    cycle(3'd0, 32'h0, 1'b0, 8'h08);

`ifndef DEMUX8_OVERWRITE_EN
    // Backpressure on a full channel, then ack and write in the same cycle.
    cycle(3'd5, 32'h11, 1'b1, 8'h00);
    s = 3'd5; d = 32'h22; in_valid = 1'b1; #1;
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    cycle(3'd5, 32'h22, 1'b1, 8'h00);
    chk("bp_y5_held", {32'd0, y5}, 64'h11);
    cycle(3'd5, 32'h22, 1'b1, 8'h20);
    chk("bp_y5_new", {32'd0, y5}, 64'h22);
    chk("bp_valid5", {63'd0, y_valid[5]}, 64'd1);
    cycle(3'd0, 32'h0, 1'b0, 8'h20);
`endif

    // Fill every channel, one per cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(3'(i), 32'(i), 1'b1, 8'h00);
      chk($sformatf("fill_occ%0d", i), {60'd0, occ}, 64'(i + 1));
    end
    chk("fill_y_valid", {56'd0, y_valid}, 64'hFF);
`ifndef DEMUX8_OVERWRITE_EN
    for (int i = 0; i < 8; i++) begin
      s = 3'(i); in_valid = 1'b1; #1;
      chk($sformatf("full_ready_s%0d", i), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
`endif

    // Parallel consume of a scattered subset.
    cycle(3'd0, 32'h0, 1'b0, 8'hA5);
    chk("pc_y_valid", {56'd0, y_valid}, 64'h5A);
    chk("pc_occ", {60'd0, occ}, 64'd4);
    chk("pc_y0", {32'd0, y0}, 64'd0);
    chk("pc_y2", {32'd0, y2}, 64'd2);
    cycle(3'd0, 32'h0, 1'b0, 8'h5A);

    // Spurious acks on an empty block.
    cycle(3'd0, 32'h0, 1'b0, 8'hFF);
    chk("spur_y_valid", {56'd0, y_valid}, 64'h00);
    chk("spur_occ", {60'd0, occ}, 64'd0);

    // Write plus ack on the same channel while another channel is consumed.
    cycle(3'd1, 32'h55, 1'b1, 8'h00);
    cycle(3'd6, 32'h66, 1'b1, 8'h00);
    cycle(3'd1, 32'h77, 1'b1, 8'h42);
    chk("mix_y1", {32'd0, y1}, 64'h77);
    chk("mix_occ", {60'd0, occ}, 64'd1);
    cycle(3'd0, 32'h0, 1'b0, 8'h02);

    // Asynchronous reset between clock edges.
    cycle(3'd4, 32'h44, 1'b1, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_y4", {32'd0, y4}, 64'd0);
    chk("arst_y_valid", {56'd0, y_valid}, 64'h00);
    chk("arst_occ", {60'd0, occ}, 64'd0);
    model_clear();
    @(posedge clk); #1;
    reset_n = 1'b1;

`ifdef DEMUX8_OVERWRITE_EN
    // Overwrite without ack: accepted, flagged, occupancy unchanged.
    cycle(3'd2, 32'hA1, 1'b1, 8'h00);
    cycle(3'd2, 32'hB2, 1'b1, 8'h00);
    chk("ow_y2", {32'd0, y2}, 64'hB2);
    chk("ow_ovf", {56'd0, ovf}, 64'h04);
    chk("ow_occ", {60'd0, occ}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
